dot_vec_tx_20: RTL and testbench

Transmit side of the 20-element dot-product input stream. A local controller loads a 20-word vector into an internal buffer through a simple write port, then pulses `start`. The block streams the buffered words as one AXI4-Stream packet, with TLAST on word 20, into the dot-product engine's input port. It honours backpressure, reports completion, and keeps the buffer so the same vector can be resent.

---
 rtl/dot_vec_tx_20.sv | 94 +++++++++
 tb/tb_dot_vec_tx_20.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_vec_tx_20.sv
// Vector transmitter: buffers VEC_LEN words written by a local controller and
// streams them as one AXI4-Stream packet (TLAST on the final word) per start.
module dot_vec_tx_20 #(
  parameter  int DATA_WIDTH = 32,
  parameter  int VEC_LEN    = 20,
  localparam int AW         = $clog2(VEC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] OUTPUT_AXIS_TDATA,
  output logic                  OUTPUT_AXIS_TLAST,
  output logic                  OUTPUT_AXIS_TVALID,
  input  logic                  OUTPUT_AXIS_TREADY
);

  localparam logic [AW-1:0] LAST_IDX = AW'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buf_q [VEC_LEN];
  logic                  buf_we;
  logic                  beat_accepted;

  // Writes land only while idle so an in-flight packet is never torn.
  assign buf_we        = wr_en && !rst && (state_q == IDLE) && (wr_addr <= LAST_IDX);
  assign beat_accepted = (state_q == SEND) && OUTPUT_AXIS_TREADY;

  // NOTE: the vector buffer has no reset; it must survive rst so the same
  // vector can be resent, and leaving it unreset keeps it plain flops/RAM.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking
  // form here would race against every other process reading these registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (beat_accepted) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    OUTPUT_AXIS_TVALID = (state_q == SEND);
    OUTPUT_AXIS_TLAST  = (state_q == SEND) && (idx_q == LAST_IDX);
    OUTPUT_AXIS_TDATA  = (state_q == SEND) ? buf_q[idx_q] : '0;
    busy               = (state_q == SEND);
    done               = (state_q == DONE);
  end

endmodule

// File: tb/tb_dot_vec_tx_20.sv
// Self-checking bench for dot_vec_tx_20: a buffer model feeds a scoreboard of
// expected beats, which a negedge monitor pops as the DUT completes handshakes.
module tb_dot_vec_tx_20;

  localparam int DW = 32;
  localparam int VL = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb [$];
  logic [DW-1:0] mdl [VL];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;

  dot_vec_tx_20 #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
    .clk                (clk),
    .rst                (rst),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .OUTPUT_AXIS_TDATA  (tdata),
    .OUTPUT_AXIS_TLAST  (tlast),
    .OUTPUT_AXIS_TVALID (tvalid),
    .OUTPUT_AXIS_TREADY (tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, done timing, stall stability, idle outputs.
  logic          done_exp   = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (mon_en) begin
      beat_t exp_beat;
      check("done", done, done_exp);
      check("busy_vs_valid", busy, tvalid);
      if (!tvalid) begin
        check("idle_tdata", tdata, '0);
        check("idle_tlast", tlast, 1'b0);
      end
      if (stall_prev) begin
        check("stall_valid", tvalid, 1'b1);
        check("stall_tdata", tdata, prev_data);
        check("stall_tlast", tlast, prev_last);
      end
      if (tvalid && tready && !rst) begin
        if (sb.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          exp_beat = sb.pop_front();
          check("beat_tdata", tdata, exp_beat.data);
          check("beat_tlast", tlast, exp_beat.last);
        end
      end
      done_exp   = !rst && tvalid && tready && tlast;
      stall_prev = !rst && tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic write_word(input logic [4:0] addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_packet();
    for (int i = 0; i < VL; i++) sb.push_back('{data: mdl[i], last: (i == VL - 1)});
  endtask

  task automatic run_packet(input bit toggle, input bit disturb, input bit wr_start,
                            input int exp_lat);
    int cyc = -1;
    start = 1'b1;
    if (wr_start) begin
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'hBEEF;
      mdl[5]  = 32'hBEEF;
    end
    push_packet();
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tready = toggle ? (c % 2 == 1) : 1'b1;
      if (disturb) begin
        wr_en   = (c >= 3 && c <= 6);
        wr_addr = 5'd0;
        wr_data = 32'hDEAD;
        start   = (c == 5 || c == 10);
      end
      @(negedge clk);
      if (c == 1) check("busy_first_cycle", busy, 1'b1);
      if (done) begin
        cyc = c;
        check("busy_at_done", busy, 1'b0);
        break;
      end
      @(posedge clk); #1;
    end
    start  = 1'b0;
    wr_en  = 1'b0;
    check("done_latency", cyc, exp_lat);
    check("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    tready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tdata", tdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < VL; i++) begin
      mdl[i] = DW'(i + 100);
      write_word(5'(i), DW'(i + 100));
    end

    // Full-rate packet, then alternating backpressure.
    run_packet(1'b0, 1'b0, 1'b0, 21);
    run_packet(1'b1, 1'b0, 1'b0, 40);

    // Writes and extra starts during SEND are dropped; resend proves it.
    run_packet(1'b0, 1'b1, 1'b0, 21);
    repeat (5) @(posedge clk);
    #1;
    run_packet(1'b0, 1'b0, 1'b0, 21);

    // Write coinciding with start is visible in the stream.
    run_packet(1'b0, 1'b0, 1'b1, 21);

    // Out-of-range addresses leave the buffer untouched.
    write_word(5'd20, 32'h1111);
    write_word(5'd31, 32'h2222);
    run_packet(1'b0, 1'b0, 1'b0, 21);

    // Reset after beat 7 accepted abandons the packet; buffer survives.
    tready = 1'b1;
    start  = 1'b1;
    push_packet();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("beats_before_rst", sb.size(), VL - 7);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("post_rst_tvalid", tvalid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle_valid", tvalid, 1'b0);
    end
    @(posedge clk); #1;
    run_packet(1'b0, 1'b0, 1'b0, 21);

    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
